// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: shared constants, register map and FSM encoding for the interrupt controller
package int_ctrl_pkg;
  localparam int NUM_SRC = 6;
  localparam logic [1:0] ADDR_MASK = 2'd0;
  localparam logic [1:0] ADDR_MODE = 2'd1;
  localparam logic [1:0] ADDR_PEND = 2'd2;
  localparam logic [1:0] ADDR_STAT = 2'd3;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;
endpackage

// File: rtl/prio_enc6.sv
// prio_enc6: lowest-index-wins priority encoder over the six active sources
module prio_enc6
  import int_ctrl_pkg::*;
(
  input  logic [NUM_SRC-1:0] active,
  output logic [2:0]         id,
  output logic               valid
);
  always_comb begin
    id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (active[i]) id = 3'(i);
  end
  assign valid = |active;
endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: six-source interrupt controller with per-source edge/level mode,
// masking, fixed priority and a req/ack/EOI handshake to the CPU
module int_ctrl
  import int_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        enabled,
  input  logic [3:2]  addr,
  output logic [31:0] data_out,
  input  logic [5:0]  irq_in,
  output logic        int_req,
  output logic [2:0]  int_id,
  input  logic        int_ack
);
  logic [5:0] mask, mode, pend, irq_prev;
  logic [5:0] rise, clr, pend_nxt, active;
  logic [2:0] win_id;
  logic       win_valid, in_service, ack_ok, eoi;
  state_t     state;
  assign rise   = irq_in & ~irq_prev;
  assign ack_ok = state == REQ && int_ack;
  assign eoi    = enabled && addr == ADDR_STAT && state == SERVICE;
  // set beats clear: a rise on the same edge as a write-clear or ack keeps the bit pending
  assign clr      = (enabled && addr == ADDR_PEND ? data_in[5:0] : 6'b0) | (ack_ok ? 6'b1 << int_id : 6'b0);
  assign pend_nxt = (mode & ((pend & ~clr) | rise)) | (~mode & irq_in);
  assign active   = pend & mask;
  prio_enc6 u_prio (
    .active(active),
    .id    (win_id),
    .valid (win_valid)
  );
  always_comb
    data_out = addr == ADDR_MASK ? {26'b0, mask} :
               addr == ADDR_MODE ? {26'b0, mode} :
               addr == ADDR_PEND ? {26'b0, pend} :
                                   {26'b0, in_service, int_id, state};
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask     <= '0;
      mode     <= '0;
      pend     <= '0;
      irq_prev <= '0;
    end else begin
      irq_prev <= irq_in;
      pend     <= pend_nxt;
      if (enabled && addr == ADDR_MASK) mask <= data_in[5:0];
      if (enabled && addr == ADDR_MODE) mode <= data_in[5:0];
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      int_req    <= 1'b0;
      int_id     <= '0;
      in_service <= 1'b0;
    end else begin
      case (state)
        IDLE: if (win_valid) begin
          state   <= REQ;
          int_req <= 1'b1;
          int_id  <= win_id;
        end
        REQ: if (int_ack) begin
          state      <= SERVICE;
          int_req    <= 1'b0;
          in_service <= 1'b1;
        end
        SERVICE: if (eoi) begin
          state      <= IDLE;
          in_service <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          int_req    <= 1'b0;
          in_service <= 1'b0;
        end
      endcase
    end
  end
endmodule
